// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-detection inputs and per-stage control outputs
// of the pipeline hazard sequencer; master drives the hazard inputs, slave is the sequencer.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  id_use_rs1_i;
    logic                  id_use_rs2_i;
    logic                  ex_mem_read_i;
    logic                  ex_mispredict_i;
    logic                  ex_mc_start_i;
    logic                  mc_done_i;
    logic                  mem_stall_i;
    logic                  pc_en_o;
    logic                  if_id_en_o;
    logic                  if_id_flush_o;
    logic                  id_ex_en_o;
    logic                  id_ex_flush_o;
    logic                  ex_mem_bubble_o;
    logic                  mc_busy_o;
    logic                  mc_timeout_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, ex_rd_i, id_use_rs1_i, id_use_rs2_i, ex_mem_read_i,
               ex_mispredict_i, ex_mc_start_i, mc_done_i, mem_stall_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_bubble_o, mc_busy_o, mc_timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, ex_rd_i, id_use_rs1_i, id_use_rs2_i, ex_mem_read_i,
               ex_mispredict_i, ex_mc_start_i, mc_done_i, mem_stall_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_bubble_o, mc_busy_o, mc_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for PC, IF/ID, ID/EX and EX/MEM, covering
// memory back-pressure, mispredicts, load-use hazards and multi-cycle EX ops.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int MW = $clog2(MC_TIMEOUT);
    localparam logic [REG_ADDR_W-1:0] R0 = '0;

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    mc_cnt_q, mc_cnt_d;
    logic             done_seen_q, done_seen_d;
    logic             mc_timeout_q, mc_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use, release_w, expire;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, bubble, busy;

    assign load_use = bus.ex_mem_read_i && (bus.ex_rd_i != R0) &&
                      ((bus.id_use_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
                       (bus.id_use_rs2_i && bus.id_rs2_i == bus.ex_rd_i));
    assign release_w = (done_seen_q || bus.mc_done_i) && !bus.mem_stall_i;
    assign expire    = mc_cnt_q == MW'(MC_TIMEOUT - 1);

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        bubble       = 1'b0;
        busy         = state_q == MC_WAIT;
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        done_seen_d  = done_seen_q;
        mc_timeout_d = mc_timeout_q;
        if (state_q == RUN) begin
            if (bus.mem_stall_i) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
            end else if (bus.ex_mispredict_i) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (bus.ex_mc_start_i) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_en    = 1'b0;
                bubble      = 1'b1;
                state_d     = MC_WAIT;
                mc_cnt_d    = '0;
                done_seen_d = 1'b0;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end else begin
            mc_cnt_d    = mc_cnt_q + 1'b1;
            done_seen_d = done_seen_q || bus.mc_done_i;
            // A timeout releases exactly like a real completion so the pipeline never deadlocks.
            if (release_w || expire) begin
                state_d      = RUN;
                mc_timeout_d = mc_timeout_q || !release_w;
            end else begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                bubble   = 1'b1;
            end
        end
        if (reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            bubble      = 1'b1;
            busy        = 1'b0;
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(!pc_en && !(&stall_cnt_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            mc_cnt_q     <= '0;
            done_seen_q  <= 1'b0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mc_cnt_q     <= mc_cnt_d;
            done_seen_q  <= done_seen_d;
            mc_timeout_q <= mc_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.pc_en_o         = pc_en;
    assign bus.if_id_en_o      = if_id_en;
    assign bus.if_id_flush_o   = if_id_flush;
    assign bus.id_ex_en_o      = id_ex_en;
    assign bus.id_ex_flush_o   = id_ex_flush;
    assign bus.ex_mem_bubble_o = bubble;
    assign bus.mc_busy_o       = busy;
    assign bus.mc_timeout_o    = mc_timeout_q;
    assign bus.stall_cnt_o     = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed controls, checked by a
// scoreboard monitor on the falling edge.
module tb_pipeline_hazard_ctrl;
    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, mc_busy}
    localparam logic [6:0] RSTC = 7'b0010110;
    localparam logic [6:0] RUNC = 7'b1101000;
    localparam logic [6:0] MSTL = 7'b0000000;
    localparam logic [6:0] MISP = 7'b1111100;
    localparam logic [6:0] LUSE = 7'b0001100;
    localparam logic [6:0] MCST = 7'b0000010;
    localparam logic [6:0] MCWT = 7'b0000011;
    localparam logic [6:0] RELS = 7'b1101001;

    typedef struct {
        int         id;
        logic [6:0] ctl;
        logic       to;
        int         sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4)) bus ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MC_TIMEOUT(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic mp, input logic ms, input logic md,
                        input logic st, input logic [6:0] c, input logic to, input int sc);
        exp_t e;
        @(posedge clk);
        #1;
        reset               = r;
        bus.id_rs1_i        = rs1;
        bus.id_rs2_i        = rs2;
        bus.id_use_rs1_i    = u1;
        bus.id_use_rs2_i    = u2;
        bus.ex_rd_i         = rd;
        bus.ex_mem_read_i   = mr;
        bus.ex_mispredict_i = mp;
        bus.ex_mc_start_i   = ms;
        bus.mc_done_i       = md;
        bus.mem_stall_i     = st;
        step_no++;
        e.id  = step_no;
        e.ctl = c;
        e.to  = to;
        e.sc  = sc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [6:0] got;
            e = sb.pop_front();
            got = {bus.pc_en_o, bus.if_id_en_o, bus.if_id_flush_o, bus.id_ex_en_o,
                   bus.id_ex_flush_o, bus.ex_mem_bubble_o, bus.mc_busy_o};
            checks += 3;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL step%0d ctl got %b exp %b", e.id, got, e.ctl);
            end
            if (bus.mc_timeout_o !== e.to) begin
                errors++;
                $display("FAIL step%0d mc_timeout got %b exp %b", e.id, bus.mc_timeout_o, e.to);
            end
            if (bus.stall_cnt_o !== 4'(e.sc)) begin
                errors++;
                $display("FAIL step%0d stall_cnt got %0d exp %0d", e.id, bus.stall_cnt_o, e.sc);
            end
        end
    end

    initial begin
        bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.ex_rd_i = '0;
        bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0; bus.ex_mem_read_i = 0;
        bus.ex_mispredict_i = 0; bus.ex_mc_start_i = 0; bus.mc_done_i = 0; bus.mem_stall_i = 0;
        //   r rs1 rs2 u1 u2 rd mr mp ms md st  ctl  to sc
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 0);
        // load-use detection
        step(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, 0, LUSE, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, RUNC, 0, 1);
        step(0, 7, 0, 1, 0, 7, 1, 0, 0, 0, 0, LUSE, 0, 1);
        step(0, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, RUNC, 0, 2);
        step(0, 0, 5, 0, 1, 5, 0, 0, 0, 0, 0, RUNC, 0, 2);
        // mispredict beats load-use and mc_start
        step(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0, MISP, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, MISP, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 2);
        // memory stall beats mispredict; stray mc_done in RUN ignored
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, MSTL, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNC, 0, 3);
        // multi-cycle op, done 4 cycles after start
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MCST, 0, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCWT, 0, 4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCWT, 0, 5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, MCWT, 0, 6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RELS, 0, 7);
        step(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, 0, LUSE, 0, 7);
        // done arrives under memory stall, release when stall drops
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MCST, 0, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCWT, 0, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MCWT, 0, 10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MCWT, 0, 11);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MCWT, 0, 12);
        step(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, 0, RELS, 0, 13);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 13);
        // timeout after 8 frozen cycles; counter saturates at 15
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MCST, 0, 13);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCWT, 0, 14);
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCWT, 0, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RELS, 0, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 1, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MSTL, 1, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 1, 15);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTC, 1, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 0);
        // reset in the middle of MC_WAIT abandons the op
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MCST, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCWT, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTC, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 0);
        for (int i = 0; i < 4 && sb.size() != 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
